// File: rtl/fetch_unit.sv
// Instruction fetch front-end: one outstanding memory request, DEPTH-entry {pc, instr} FIFO to decode.
// Build with FETCH_PERF_EN defined to get the stall/redirect performance counters.
module fetch_unit #(
  parameter int                           INS_ADDRESS_WIDTH = 20,
  parameter int                           DATA_WIDTH        = 32,
  parameter int                           DEPTH             = 4,
  parameter logic [INS_ADDRESS_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         mem_req,
  output logic [INS_ADDRESS_WIDTH-1:0] mem_addr,
  input  logic                         mem_rvalid,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  input  logic                         redirect_valid,
  input  logic [INS_ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                         instr_valid,
  output logic [DATA_WIDTH-1:0]        instr,
  output logic [INS_ADDRESS_WIDTH-1:0] instr_pc,
  input  logic                         instr_ready,
  output logic [31:0]                  perf_stall_cnt,
  output logic [31:0]                  perf_redirect_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t                       r_state;
  logic [CNT_W-1:0]             r_count;
  logic [PTR_W-1:0]             r_head, r_tail;
  logic [INS_ADDRESS_WIDTH-1:0] r_fetch_pc, r_req_pc;
  logic [DATA_WIDTH-1:0]        r_data [DEPTH];
  logic [INS_ADDRESS_WIDTH-1:0] r_pc   [DEPTH];

  logic                         w_push, w_pop, w_space;
  logic [CNT_W:0]               w_sum;
  logic [INS_ADDRESS_WIDTH-1:0] w_redir_pc;

  assign w_push     = mem_rvalid & (r_state == S_WAIT) & ~redirect_valid;
  assign w_pop      = instr_valid & instr_ready & ~redirect_valid;
  // Pop is deliberately not credited so issue never depends on instr_ready.
  assign w_sum      = {1'b0, r_count} + (CNT_W+1)'(w_push);
  assign w_space    = w_sum < (CNT_W+1)'(DEPTH);
  assign w_redir_pc = redirect_pc & ~INS_ADDRESS_WIDTH'(3);

  assign mem_req  = ~rst & ~redirect_valid & w_space &
                    ((r_state == S_IDLE) | ((r_state == S_WAIT) & mem_rvalid));
  assign mem_addr = r_fetch_pc;

  assign instr_valid = (r_count != '0);
  assign instr       = r_data[r_head];
  assign instr_pc    = r_pc[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_fetch_pc <= w_redir_pc;
      if (r_state == S_WAIT)
        r_state <= mem_rvalid ? S_IDLE : S_DISCARD;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (mem_req) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + INS_ADDRESS_WIDTH'(4);
        r_state    <= S_WAIT;
      end else if (mem_rvalid && r_state != S_IDLE) begin
        r_state <= S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_tail] <= mem_rdata;
      r_pc[r_tail]   <= r_req_pc;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_stall_cnt, r_redirect_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (instr_ready & ~instr_valid) r_stall_cnt    <= r_stall_cnt + 32'd1;
      if (redirect_valid)             r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt    = r_stall_cnt;
  assign perf_redirect_cnt = r_redirect_cnt;
`else
  assign perf_stall_cnt    = '0;
  assign perf_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency instruction memory model (rdata = addr | 0xA000_0000).
module tb_fetch_unit;
  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [19:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [19:0] instr_pc;
  logic        instr_ready;
  logic [31:0] perf_stall_cnt, perf_redirect_cnt;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          lat   = 1;
  int          due   = 0;
  int          req_cnt = 0;
  logic        pend  = 1'b0;
  logic [19:0] pend_addr = '0;

  logic        s_req, s_iv;
  logic [19:0] s_addr, s_ipc;
  logic [31:0] s_ins, s_pst, s_prd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Samples one cycle at negedge, records any request, then sets up the next cycle's response.
  task automatic step();
    @(negedge clk);
    s_req = mem_req; s_addr = mem_addr; s_iv = instr_valid;
    s_ins = instr;   s_ipc  = instr_pc;
    s_pst = perf_stall_cnt; s_prd = perf_redirect_cnt;
    if (mem_req) begin
      pend = 1'b1; due = lat; pend_addr = mem_addr; req_cnt++;
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (pend) begin
      due--;
      if (due == 0) begin
        pend       = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA000_0000 | 32'(pend_addr);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    pend = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; req_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    @(posedge clk); #1;

    // reset state
    do_reset();
    chk("rst_req", s_req, 0);
    chk("rst_iv",  s_iv,  0);

    // streaming at 1 instr/cycle
    lat = 1; instr_ready = 1'b1;
    step(); chk("a0_req", s_req, 1); chk("a0_addr", s_addr, 20'h0); chk("a0_iv", s_iv, 0);
    step(); chk("a1_req", s_req, 1); chk("a1_addr", s_addr, 20'h4); chk("a1_iv", s_iv, 0);
    step(); chk("a2_addr", s_addr, 20'h8); chk("a2_iv", s_iv, 1);
            chk("a2_pc", s_ipc, 20'h0); chk("a2_ins", s_ins, 32'hA000_0000);
    step(); chk("a3_iv", s_iv, 1); chk("a3_pc", s_ipc, 20'h4); chk("a3_ins", s_ins, 32'hA000_0004);
    step(); chk("a4_iv", s_iv, 1); chk("a4_pc", s_ipc, 20'h8); chk("a4_ins", s_ins, 32'hA000_0008);

    // fill to DEPTH with decode stalled, then a single pop
    do_reset();
    lat = 1; instr_ready = 1'b0;
    repeat (4) step();
    chk("b3_addr", s_addr, 20'hC);
    step(); chk("b4_req", s_req, 0);
    step(); chk("b5_req", s_req, 0); chk("b5_iv", s_iv, 1); chk("b5_pc", s_ipc, 20'h0);
    chk("b_nreq", req_cnt, 4);
    instr_ready = 1'b1;
    step(); chk("b6_req", s_req, 0); chk("b6_pc", s_ipc, 20'h0);
    instr_ready = 1'b0;
    step(); chk("b7_req", s_req, 1); chk("b7_addr", s_addr, 20'h10); chk("b7_pc", s_ipc, 20'h4);

    // redirect while a 3-cycle request is outstanding
    do_reset();
    lat = 3; instr_ready = 1'b0;
    repeat (7) step();
    chk("c6_req", s_req, 1); chk("c6_addr", s_addr, 20'h8);
    redirect_valid = 1'b1; redirect_pc = 20'h43;
    step(); chk("c7_req", s_req, 0); chk("c7_iv", s_iv, 1);
    redirect_valid = 1'b0;
    step(); chk("c8_iv", s_iv, 0); chk("c8_req", s_req, 0);
    step(); chk("c9_req", s_req, 0); chk("c9_iv", s_iv, 0);
    step(); chk("c10_req", s_req, 1); chk("c10_addr", s_addr, 20'h40);
    instr_ready = 1'b1;
    repeat (3) step();
    step(); chk("c14_iv", s_iv, 1); chk("c14_pc", s_ipc, 20'h40); chk("c14_ins", s_ins, 32'hA000_0040);

    // redirect coinciding with response and pop, count=2
    do_reset();
    lat = 1; instr_ready = 1'b0;
    repeat (3) step();
    chk("d2_addr", s_addr, 20'h8);
    redirect_valid = 1'b1; redirect_pc = 20'h80; instr_ready = 1'b1;
    step(); chk("d3_req", s_req, 0); chk("d3_iv", s_iv, 1); chk("d3_pc", s_ipc, 20'h0);
    redirect_valid = 1'b0;
    step(); chk("d4_req", s_req, 1); chk("d4_addr", s_addr, 20'h80); chk("d4_iv", s_iv, 0);
    step(); chk("d5_iv", s_iv, 0); chk("d5_addr", s_addr, 20'h84);
    step(); chk("d6_iv", s_iv, 1); chk("d6_pc", s_ipc, 20'h80); chk("d6_ins", s_ins, 32'hA000_0080);

    // reset with a request outstanding; stale response lands after release
    do_reset();
    lat = 3; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 20'h200;
    step(); chk("e0_req", s_req, 0);
    redirect_valid = 1'b0;
    step(); chk("e1_req", s_req, 1); chk("e1_addr", s_addr, 20'h200);
    rst = 1'b1;
    step(); chk("e2_req", s_req, 0);
    step(); chk("e3_req", s_req, 0); chk("e3_iv", s_iv, 0);
    rst = 1'b0;
    step(); chk("e4_req", s_req, 1); chk("e4_addr", s_addr, 20'h0); chk("e4_iv", s_iv, 0);
    step(); chk("e5_iv", s_iv, 0);
    step(); chk("e6_iv", s_iv, 0);
    step();
    step(); chk("e8_iv", s_iv, 1); chk("e8_pc", s_ipc, 20'h0); chk("e8_ins", s_ins, 32'hA000_0000);

    // performance counters: 5 empty-stall cycles, 2 redirect cycles
    do_reset();
    lat = 3; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 20'h10;
    step(); chk("f0_stall", s_pst, 0); chk("f0_redir", s_prd, 0);
    redirect_pc = 20'h20;
    step();
    redirect_valid = 1'b0;
    step(); chk("f2_req", s_req, 1); chk("f2_addr", s_addr, 20'h20);
    step();
    step();
    step();
`ifdef FETCH_PERF_EN
    chk("f5_stall", s_pst, 5); chk("f5_redir", s_prd, 2);
`else
    chk("f5_stall", s_pst, 0); chk("f5_redir", s_prd, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
